// File: rtl/apb4_gpio_filt.sv
// APB4 GPIO controller with per-pin input synchroniser, debounce filter,
// atomic set/clear of the output register and sticky W1C interrupt status.
// Register index is paddr[5:2]; indices 12..15 answer with pslverr.
module apb4_gpio_filt #(
    parameter int PIN_NUM    = 32,
    parameter int SYNC_STAGE = 2,
    parameter int DBNC_WIDTH = 8
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [31:0]        paddr,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [PIN_NUM-1:0] gpio_in_i,
    output logic [PIN_NUM-1:0] gpio_dir_o,
    output logic [PIN_NUM-1:0] gpio_out_o,
    output logic [PIN_NUM-1:0] gpio_iof_o,
    output logic               irq_o
);

    localparam logic [3:0] IDX_PADDIR   = 4'd0;
    localparam logic [3:0] IDX_PADIN    = 4'd1;
    localparam logic [3:0] IDX_PADOUT   = 4'd2;
    localparam logic [3:0] IDX_OUTSET   = 4'd3;
    localparam logic [3:0] IDX_OUTCLR   = 4'd4;
    localparam logic [3:0] IDX_INTEN    = 4'd5;
    localparam logic [3:0] IDX_INTTYPE0 = 4'd6;
    localparam logic [3:0] IDX_INTTYPE1 = 4'd7;
    localparam logic [3:0] IDX_INTSTAT  = 4'd8;
    localparam logic [3:0] IDX_DBNCEN   = 4'd9;
    localparam logic [3:0] IDX_DBNCDIV  = 4'd10;
    localparam logic [3:0] IDX_IOFCFG   = 4'd11;

    // Zero-extend a pin-wide register onto the 32-bit read bus.
    function automatic logic [31:0] pad_pins(input logic [PIN_NUM-1:0] v);
        logic [31:0] r;
        r = '0;
        r[PIN_NUM-1:0] = v;
        return r;
    endfunction

    // Zero-extend the debounce divider onto the 32-bit read bus.
    function automatic logic [31:0] pad_div(input logic [DBNC_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[DBNC_WIDTH-1:0] = v;
        return r;
    endfunction

    // Bus decode
    logic [3:0]         idx;
    logic               acc;
    logic               err;
    logic               wr;
    logic               rd;
    logic [PIN_NUM-1:0] wpins;

    // Software-visible registers
    logic [PIN_NUM-1:0]    dir;
    logic [PIN_NUM-1:0]    out;
    logic [PIN_NUM-1:0]    inten;
    logic [PIN_NUM-1:0]    type0;
    logic [PIN_NUM-1:0]    type1;
    logic [PIN_NUM-1:0]    intstat;
    logic [PIN_NUM-1:0]    dbncen;
    logic [DBNC_WIDTH-1:0] dbncdiv;
    logic [PIN_NUM-1:0]    iof;

    // Input path
    logic [PIN_NUM-1:0]    sync_q [SYNC_STAGE];
    logic [PIN_NUM-1:0]    sync;
    logic [PIN_NUM-1:0]    filt_p0;
    logic [PIN_NUM-1:0]    filt_p1;
    logic [DBNC_WIDTH-1:0] cnt [PIN_NUM];

    // Interrupt sources
    logic [PIN_NUM-1:0] rise;
    logic [PIN_NUM-1:0] fall;
    logic [PIN_NUM-1:0] cond;
    logic [PIN_NUM-1:0] hit;
    logic [PIN_NUM-1:0] w1c;

    // Address bits outside [5:2] and data bits above PIN_NUM carry no meaning.
    logic unused_bus;
    assign unused_bus = ^{paddr[31:6], paddr[1:0], pwdata};

    assign idx   = paddr[5:2];
    assign acc   = psel & penable;
    assign err   = acc & idx[3] & idx[2];
    assign wr    = acc & pwrite & ~err;
    assign rd    = acc & ~pwrite & ~err & presetn;
    assign wpins = pwdata[PIN_NUM-1:0];

    assign pready  = 1'b1;
    assign pslverr = err & presetn;

    // Control registers: plain writes plus atomic set/clear of the output value.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            dir     <= '0;
            out     <= '0;
            inten   <= '0;
            type0   <= '0;
            type1   <= '0;
            dbncen  <= '0;
            dbncdiv <= '0;
            iof     <= '0;
        end else if (wr) begin
            case (idx)
                IDX_PADDIR:   dir     <= wpins;
                IDX_PADOUT:   out     <= wpins;
                IDX_OUTSET:   out     <= out | wpins;
                IDX_OUTCLR:   out     <= out & ~wpins;
                IDX_INTEN:    inten   <= wpins;
                IDX_INTTYPE0: type0   <= wpins;
                IDX_INTTYPE1: type1   <= wpins;
                IDX_DBNCEN:   dbncen  <= wpins;
                IDX_DBNCDIV:  dbncdiv <= pwdata[DBNC_WIDTH-1:0];
                IDX_IOFCFG:   iof     <= wpins;
                default: ;
            endcase
        end
    end

    // --- stage: pad synchroniser chain, sync is the last flop ---
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int s = 0; s < SYNC_STAGE; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_in_i;
            for (int s = 1; s < SYNC_STAGE; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGE-1];

    // --- stage p0: debounce filter; a pin moves only after DBNCDIV+1 disagreeing cycles ---
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            filt_p0 <= '0;
            for (int i = 0; i < PIN_NUM; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIN_NUM; i++) begin
                if (!dbncen[i]) begin
                    filt_p0[i] <= sync[i];
                    cnt[i]     <= '0;
                end else if (sync[i] == filt_p0[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == dbncdiv) begin
                    filt_p0[i] <= sync[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DBNC_WIDTH'(1);
                end
            end
        end
    end

    // --- stage p1: one-cycle delayed filtered value for edge detection ---
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            filt_p1 <= '0;
        end else begin
            filt_p1 <= filt_p0;
        end
    end

    assign rise = filt_p0 & ~filt_p1;
    assign fall = ~filt_p0 & filt_p1;

    // {type1,type0}: 00 level-high, 01 level-low, 10 rise, 11 fall
    assign cond = (~type1 & ~type0 & filt_p0)
                | (~type1 &  type0 & ~filt_p0)
                | ( type1 & ~type0 & rise)
                | ( type1 &  type0 & fall);
    assign hit  = inten & cond;
    assign w1c  = (wr && idx == IDX_INTSTAT) ? wpins : '0;

    // Sticky status: a new hit wins over a write-one-to-clear in the same cycle.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            intstat <= '0;
        end else begin
            intstat <= (intstat & ~w1c) | hit;
        end
    end

    assign irq_o      = |intstat;
    assign gpio_dir_o = dir;
    assign gpio_out_o = out;
    assign gpio_iof_o = iof;

    // Read mux: zero outside a valid read access; write-only registers read 0.
    always_comb begin
        prdata = '0;
        if (rd) begin
            case (idx)
                IDX_PADDIR:   prdata = pad_pins(dir);
                IDX_PADIN:    prdata = pad_pins(filt_p0);
                IDX_PADOUT:   prdata = pad_pins(out);
                IDX_INTEN:    prdata = pad_pins(inten);
                IDX_INTTYPE0: prdata = pad_pins(type0);
                IDX_INTTYPE1: prdata = pad_pins(type1);
                IDX_INTSTAT:  prdata = pad_pins(intstat);
                IDX_DBNCEN:   prdata = pad_pins(dbncen);
                IDX_DBNCDIV:  prdata = pad_div(dbncdiv);
                IDX_IOFCFG:   prdata = pad_pins(iof);
                default:      prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_gpio_filt.sv
// Scoreboard bench for apb4_gpio_filt: a 32-pin instance (a) and an 8-pin
// instance (b) share the APB bus and pads; each has its own psel.
module tb_apb4_gpio_filt;

    localparam logic [31:0] A_PADDIR   = 32'h00;
    localparam logic [31:0] A_PADIN    = 32'h04;
    localparam logic [31:0] A_PADOUT   = 32'h08;
    localparam logic [31:0] A_OUTSET   = 32'h0C;
    localparam logic [31:0] A_OUTCLR   = 32'h10;
    localparam logic [31:0] A_INTEN    = 32'h14;
    localparam logic [31:0] A_INTTYPE0 = 32'h18;
    localparam logic [31:0] A_INTTYPE1 = 32'h1C;
    localparam logic [31:0] A_INTSTAT  = 32'h20;
    localparam logic [31:0] A_DBNCEN   = 32'h24;
    localparam logic [31:0] A_DBNCDIV  = 32'h28;
    localparam logic [31:0] A_IOFCFG   = 32'h2C;

    typedef enum int {K_RD, K_PRD, K_OUT, K_DIR_A, K_DIR_B, K_IOF, K_IRQ, K_RDY} kind_t;
    typedef struct {
        kind_t       kind;
        logic [32:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [31:0] paddr = '0;
    logic        psel_a = 1'b0;
    logic        psel_b = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] gpio_in = '0;
    logic        probe = 1'b0;

    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b, irq_a, irq_b;
    logic [31:0] dir_a, out_a, iof_a;
    logic [7:0]  dir_b, out_b, iof_b;

    apb4_gpio_filt dut_a (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel_a),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
        .gpio_in_i(gpio_in), .gpio_dir_o(dir_a), .gpio_out_o(out_a),
        .gpio_iof_o(iof_a), .irq_o(irq_a)
    );

    apb4_gpio_filt #(.PIN_NUM(8), .SYNC_STAGE(2), .DBNC_WIDTH(8)) dut_b (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel_b),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
        .gpio_in_i(gpio_in[7:0]), .gpio_dir_o(dir_b), .gpio_out_o(out_b),
        .gpio_iof_o(iof_b), .irq_o(irq_b)
    );

    always #5 pclk = ~pclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: pops one expectation whenever a read access or a probe is presented.
    always @(negedge pclk) begin
        exp_t        e;
        logic [32:0] act;
        if (((psel_a | psel_b) && penable && !pwrite) || probe) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_output: got output with empty scoreboard, want none");
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_RD, K_PRD: act = psel_b ? {pslverr_b, prdata_b} : {pslverr_a, prdata_a};
                    K_OUT:       act = {1'b0, out_a};
                    K_DIR_A:     act = {1'b0, dir_a};
                    K_DIR_B:     act = {25'b0, dir_b};
                    K_IOF:       act = {1'b0, iof_a};
                    K_IRQ:       act = {32'b0, irq_a};
                    K_RDY:       act = {31'b0, pready_a, pready_b};
                    default:     act = 'x;
                endcase
                if (act !== e.val) begin
                    n_miss++;
                    $display("FAIL %s: got %h want %h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic push(input kind_t k, input logic [32:0] v, input string nm);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic apb_wr(input bit to_b, input logic [31:0] a, input logic [31:0] d);
        paddr = a; pwdata = d; pwrite = 1'b1; penable = 1'b0;
        psel_a = !to_b; psel_b = to_b;
        step(1);
        penable = 1'b1;
        step(1);
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Expected value is {pslverr, prdata}.
    task automatic apb_rd(input bit to_b, input logic [31:0] a, input logic [32:0] ex, input string nm);
        push(K_RD, ex, nm);
        paddr = a; pwrite = 1'b0; penable = 1'b0;
        psel_a = !to_b; psel_b = to_b;
        step(1);
        penable = 1'b1;
        step(1);
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    endtask

    task automatic chk(input kind_t k, input logic [32:0] v, input string nm);
        push(k, v, nm);
        probe = 1'b1;
        step(1);
        probe = 1'b0;
    endtask

    initial begin
        // T1: reset state
        step(1);
        chk(K_RDY, 33'h3, "pready_in_reset");
        presetn = 1'b1;
        chk(K_IRQ, 33'h0, "irq_after_reset");
        chk(K_PRD, 33'h0, "prdata_idle");
        for (int r = 0; r < 12; r++) begin
            apb_rd(1'b0, 32'(r * 4), 33'h0, $sformatf("reset_reg%0d", r));
        end
        apb_rd(1'b0, 32'h34, {1'b1, 32'h0}, "slverr_idx13");

        // T2: atomic set/clear
        apb_wr(1'b0, A_PADOUT, 32'h0000_00F0);
        apb_wr(1'b0, A_OUTSET, 32'h0000_000F);
        apb_wr(1'b0, A_OUTCLR, 32'h0000_0030);
        chk(K_OUT, 33'h0CF, "gpio_out_setclr");
        apb_rd(1'b0, A_PADOUT, 33'h0CF, "padout_setclr");
        apb_rd(1'b0, A_OUTSET, 33'h0, "outset_reads0");
        apb_wr(1'b0, A_IOFCFG, 32'h0000_00A5);
        chk(K_IOF, 33'h0A5, "gpio_iof");
        apb_wr(1'b0, A_PADDIR, 32'h1234_5678);
        chk(K_DIR_A, 33'h1234_5678, "gpio_dir_a");

        // T3: debounce, DBNCDIV=4 on pin0
        apb_wr(1'b0, A_DBNCDIV, 32'd4);
        apb_wr(1'b0, A_DBNCEN, 32'h1);
        apb_rd(1'b0, A_DBNCDIV, 33'h4, "dbncdiv_rb");
        gpio_in[0] = 1'b1;
        fork
            begin
                step(3);
                gpio_in[0] = 1'b0;
            end
            begin
                apb_rd(1'b0, A_PADIN, 33'h0, "glitch_e1");
                apb_rd(1'b0, A_PADIN, 33'h0, "glitch_e3");
                apb_rd(1'b0, A_PADIN, 33'h0, "glitch_e5");
            end
        join
        step(10);
        gpio_in[0] = 1'b1;
        step(5);
        apb_rd(1'b0, A_PADIN, 33'h0, "dbnc_edge6");
        apb_rd(1'b0, A_PADIN, 33'h1, "dbnc_edge8");
        gpio_in[0] = 1'b0;
        step(12);
        apb_rd(1'b0, A_PADIN, 33'h0, "dbnc_fall");
        gpio_in[0] = 1'b1;
        step(6);
        apb_rd(1'b0, A_PADIN, 33'h1, "dbnc_edge7");

        // T4: rising-edge interrupt on pin1
        apb_wr(1'b0, A_INTTYPE1, 32'h2);
        apb_wr(1'b0, A_INTTYPE0, 32'h0);
        apb_wr(1'b0, A_INTEN, 32'h2);
        gpio_in[1] = 1'b1;
        step(3);
        chk(K_IRQ, 33'h0, "irq_before_rise");
        chk(K_IRQ, 33'h1, "irq_rise");
        apb_rd(1'b0, A_INTSTAT, 33'h2, "intstat_rise");
        apb_wr(1'b0, A_INTSTAT, 32'h2);
        chk(K_IRQ, 33'h0, "irq_w1c");
        apb_rd(1'b0, A_INTSTAT, 33'h0, "intstat_w1c");

        // T5: sticky multi-pin, set wins over W1C
        gpio_in[3] = 1'b1;
        step(6);
        apb_wr(1'b0, A_INTTYPE1, 32'h2A);
        apb_wr(1'b0, A_INTTYPE0, 32'h08);
        apb_wr(1'b0, A_INTEN, 32'h2A);
        apb_rd(1'b0, A_INTSTAT, 33'h0, "intstat_quiet");
        gpio_in[3] = 1'b0;
        gpio_in[5] = 1'b1;
        step(6);
        apb_rd(1'b0, A_INTSTAT, 33'h28, "intstat_fall_rise");
        apb_wr(1'b0, A_INTSTAT, 32'h08);
        apb_rd(1'b0, A_INTSTAT, 33'h20, "intstat_partial_w1c");
        chk(K_IRQ, 33'h1, "irq_still_set");
        gpio_in[2] = 1'b1;
        step(6);
        apb_wr(1'b0, A_INTEN, 32'h2E);
        apb_rd(1'b0, A_INTSTAT, 33'h24, "intstat_level");
        apb_wr(1'b0, A_INTSTAT, 32'h04);
        apb_rd(1'b0, A_INTSTAT, 33'h24, "level_set_wins");
        apb_wr(1'b0, A_INTEN, 32'h2A);
        step(2);
        apb_rd(1'b0, A_INTSTAT, 33'h24, "inten_off_keeps");
        apb_wr(1'b0, A_INTSTAT, 32'h24);
        apb_rd(1'b0, A_INTSTAT, 33'h0, "intstat_all_clear");
        chk(K_IRQ, 33'h0, "irq_all_clear");
        apb_rd(1'b0, A_INTTYPE1, 33'h2A, "inttype1_rb");

        // T6: 8-pin instance, masking and reset mid-debounce
        apb_rd(1'b1, A_PADIN, 33'h27, "b_padin");
        apb_wr(1'b1, A_PADDIR, 32'hFFFF_FFFF);
        apb_rd(1'b1, A_PADDIR, 33'h0FF, "b_paddir_mask");
        chk(K_DIR_B, 33'h0FF, "b_gpio_dir");
        apb_wr(1'b1, A_PADOUT, 32'hFFFF_FF00);
        apb_rd(1'b1, A_PADOUT, 33'h0, "b_padout_upper");
        apb_wr(1'b1, A_DBNCDIV, 32'd4);
        apb_wr(1'b1, A_DBNCEN, 32'hFF);
        gpio_in = '0;
        step(3);
        presetn = 1'b0;
        step(2);
        presetn = 1'b1;
        apb_rd(1'b1, A_PADIN, 33'h0, "b_padin_after_rst");
        apb_rd(1'b1, A_DBNCEN, 33'h0, "b_dbncen_after_rst");
        apb_rd(1'b1, A_DBNCDIV, 33'h0, "b_dbncdiv_after_rst");
        apb_rd(1'b1, A_PADDIR, 33'h0, "b_paddir_after_rst");
        chk(K_DIR_B, 33'h0, "b_gpio_dir_after_rst");
        apb_rd(1'b0, A_PADOUT, 33'h0, "a_padout_after_rst");
        chk(K_IOF, 33'h0, "a_iof_after_rst");

        step(2);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
